adc_captura: RTL and testbench

ADC_CAPTURA -- requirements
Module: adc_captura

---
 rtl/adc_captura.sv | 136 +++++++++++++
 tb/tb_adc_captura.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_captura.sv
`timescale 1ns/1ps
// adc_captura: periodic capture of 16-bit frames from a Pmod AD style serial ADC.
// A free-running tick counter triggers each frame. The frame drives Cs and Sclk,
// shifts in SData MSB first, and publishes the low 12 bits with a leading-zero check.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// INICIO     | idle, Cs=1, Sclk=1, waiting for a tick with Habilita=1
// CONVERSION | Cs=0, Sclk toggling every DIV cycles, sampling 16 bits
// ESPERA     | Cs=1 quiet gap of QUIET cycles; ticks are dropped here
module adc_captura #(
  parameter int DIV     = 2,
  parameter int PERIODO = 2268,
  parameter int QUIET   = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Habilita,
  input  logic        SData,
  output logic        Sclk,
  output logic        Cs,
  output logic [11:0] Data_Out,
  output logic        Rx_Listo,
  output logic        Err_Trama,
  output logic        Desborde
);

  localparam int TW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam int QW = (QUIET > 1) ? $clog2(QUIET + 1) : 1;

  typedef enum logic [1:0] {INICIO, CONVERSION, ESPERA} estado_t;

  estado_t        estado, estado_d;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [3:0]     div_cnt, div_d;
  logic [4:0]     bit_cnt, bit_d;
  logic [15:0]    shift, shift_d;
  logic [QW-1:0]  q_cnt, q_d;
  logic           sclk_d, cs_d, rx_d, err_d, des_d;
  logic [11:0]    data_d;

  assign tick = (tick_cnt == TW'(PERIODO - 1));

  // Free-running sample-period counter; tick marks its last count.
  always_ff @(posedge Clk) begin
    if (Rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  // Next-state and next-output decode; every output is registered below.
  // The 16th rising Sclk edge is also the edge that closes the frame, so the
  // published word is assembled from the shift register plus the live SData bit.
  always_comb begin
    estado_d = estado;
    div_d    = div_cnt;
    bit_d    = bit_cnt;
    shift_d  = shift;
    q_d      = q_cnt;
    sclk_d   = Sclk;
    cs_d     = Cs;
    data_d   = Data_Out;
    err_d    = Err_Trama;
    rx_d     = 1'b0;
    des_d    = 1'b0;
    unique case (estado)
      INICIO: begin
        cs_d   = 1'b1;
        sclk_d = 1'b1;
        if (tick && Habilita) begin
          estado_d = CONVERSION;
          cs_d     = 1'b0;
          div_d    = 4'(DIV - 1);
          bit_d    = 5'd0;
        end
      end
      CONVERSION: begin
        des_d = tick;
        if (div_cnt == 4'd0) begin
          div_d  = 4'(DIV - 1);
          sclk_d = ~Sclk;
          if (!Sclk) begin
            shift_d = {shift[14:0], SData};
            bit_d   = bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              estado_d = ESPERA;
              cs_d     = 1'b1;
              data_d   = {shift[10:0], SData};
              err_d    = (shift[14:11] != 4'd0);
              rx_d     = 1'b1;
              q_d      = QW'(QUIET - 1);
            end
          end
        end else begin
          div_d = div_cnt - 4'd1;
        end
      end
      ESPERA: begin
        des_d = tick;
        if (q_cnt == '0) estado_d = INICIO;
        else             q_d = q_cnt - 1'b1;
      end
      default: estado_d = INICIO;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      estado    <= INICIO;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      q_cnt     <= '0;
      Sclk      <= 1'b1;
      Cs        <= 1'b1;
      Data_Out  <= '0;
      Err_Trama <= 1'b0;
      Rx_Listo  <= 1'b0;
      Desborde  <= 1'b0;
    end else begin
      estado    <= estado_d;
      div_cnt   <= div_d;
      bit_cnt   <= bit_d;
      shift     <= shift_d;
      q_cnt     <= q_d;
      Sclk      <= sclk_d;
      Cs        <= cs_d;
      Data_Out  <= data_d;
      Err_Trama <= err_d;
      Rx_Listo  <= rx_d;
      Desborde  <= des_d;
    end
  end

endmodule

// File: tb/tb_adc_captura.sv
`timescale 1ns/1ps
// Bench for adc_captura: two instances (normal timing, and a long quiet gap that
// lets ticks land in Espera) checked every cycle against a frame-level model.
module tb_adc_captura;

  localparam int DIV_A = 2, P_A = 100, Q_A = 4;
  localparam int DIV_B = 1, P_B = 50,  Q_B = 40;

  logic Clk = 1'b0, Rst = 1'b1, Habilita = 1'b0;
  logic sdata_a = 1'b0, sdata_b = 1'b0;
  logic sclk_a, cs_a, rx_a, err_a, des_a;
  logic sclk_b, cs_b, rx_b, err_b, des_b;
  logic [11:0] data_a, data_b;

  logic [15:0] word_a = 16'h0A5C;
  logic [15:0] word_b = 16'h0123;

  always #5 Clk = ~Clk;

  adc_captura #(.DIV(DIV_A), .PERIODO(P_A), .QUIET(Q_A)) dut_a (
    .Clk(Clk), .Rst(Rst), .Habilita(Habilita), .SData(sdata_a),
    .Sclk(sclk_a), .Cs(cs_a), .Data_Out(data_a), .Rx_Listo(rx_a),
    .Err_Trama(err_a), .Desborde(des_a));

  adc_captura #(.DIV(DIV_B), .PERIODO(P_B), .QUIET(Q_B)) dut_b (
    .Clk(Clk), .Rst(Rst), .Habilita(Habilita), .SData(sdata_b),
    .Sclk(sclk_b), .Cs(cs_b), .Data_Out(data_b), .Rx_Listo(rx_b),
    .Err_Trama(err_b), .Desborde(des_b));

  int n_checks = 0, n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: a frame accepted at tick cycle fs owns cycles fs+1..fs+32*div
  // with Cs low, publishes at fs+32*div+1 and stays busy QUIET-1 cycles after that.
  int          m_idx[2]  = '{0, 0};
  int          m_fs[2]   = '{-1, -1};
  logic [15:0] m_fw[2]   = '{16'h0, 16'h0};
  logic [11:0] m_data[2] = '{12'h0, 12'h0};
  logic        m_err[2]  = '{1'b0, 1'b0};
  logic        m_des[2]  = '{1'b0, 1'b0};
  bit          m_valid[2] = '{0, 0};

  task automatic model_cmp(input int k, input logic cs, input logic sclk, input logic rx,
                           input logic err, input logic des, input logic [11:0] data,
                           input logic [15:0] word);
    int dv, q, p, idx, fs, e_sclk;
    bit in_conv, rxe, busy, tick;
    string t;
    dv = (k == 0) ? DIV_A : DIV_B;
    q  = (k == 0) ? Q_A : Q_B;
    p  = (k == 0) ? P_A : P_B;
    t  = (k == 0) ? "a" : "b";
    idx = m_idx[k];
    fs  = m_fs[k];
    if (m_valid[k]) begin
      in_conv = (fs >= 0) && (idx > fs) && (idx <= fs + 32*dv);
      rxe     = (fs >= 0) && (idx == fs + 32*dv + 1);
      if (rxe) begin
        m_data[k] = m_fw[k][11:0];
        m_err[k]  = (m_fw[k][15:12] != 4'd0);
      end
      e_sclk = in_conv ? ((((idx - fs - 1) / dv) % 2) == 0) : 1;
      chk({"cs_", t},   32'(cs),   32'(!in_conv));
      chk({"sclk_", t}, 32'(sclk), 32'(e_sclk));
      chk({"rx_", t},   32'(rx),   32'(rxe));
      chk({"data_", t}, 32'(data), 32'(m_data[k]));
      chk({"err_", t},  32'(err),  32'(m_err[k]));
      chk({"des_", t},  32'(des),  32'(m_des[k]));
    end
    if (Rst) begin
      m_idx[k] = 0; m_fs[k] = -1; m_data[k] = '0; m_err[k] = 1'b0;
      m_des[k] = 1'b0; m_valid[k] = 1'b1;
    end else begin
      busy = (fs >= 0) && (idx > fs) && (idx <= fs + 32*dv + q);
      tick = (idx % p) == (p - 1);
      m_des[k] = tick && busy;
      if (tick && !busy && Habilita) begin
        m_fs[k] = idx;
        m_fw[k] = word;
      end
      m_idx[k] = idx + 1;
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Instance A: event counters, model compare, and ADC serial model.
  int a_csf = 0, a_rx = 0, a_des = 0, a_falls = 0, a_rises = 0, t_csf_a = 0, t_rx_a = 0, rc_a = 0;
  logic prev_cs_a = 1'b1, prev_sclk_a = 1'b1;
  logic [15:0] lw_a = 16'h0;
  always @(negedge Clk) begin
    if (prev_cs_a && !cs_a) begin a_csf++; a_falls = 0; a_rises = 0; t_csf_a = cyc; end
    if (!cs_a && prev_sclk_a && !sclk_a) a_falls++;
    if (!cs_a && !prev_sclk_a && sclk_a) a_rises++;
    if (rx_a) begin a_rx++; t_rx_a = cyc; end
    if (des_a) a_des++;
    model_cmp(0, cs_a, sclk_a, rx_a, err_a, des_a, data_a, word_a);
    if (cs_a) begin
      rc_a = 0; lw_a = word_a; sdata_a = word_a[15];
    end else if (!prev_sclk_a && sclk_a) begin
      rc_a++;
      sdata_a = (rc_a < 16) ? lw_a[4'(15 - rc_a)] : 1'b0;
    end
    prev_cs_a = cs_a; prev_sclk_a = sclk_a;
  end

  // Instance B: counters over the first 200 cycles after release, model compare, ADC model.
  int b_csf = 0, b_des = 0, rc_b = 0;
  bit b_win = 1;
  logic prev_cs_b = 1'b1, prev_sclk_b = 1'b1;
  logic [15:0] lw_b = 16'h0;
  always @(negedge Clk) begin
    if (b_win && !Rst && m_valid[1] && m_idx[1] < 200) begin
      if (prev_cs_b && !cs_b) b_csf++;
      if (des_b) b_des++;
    end
    model_cmp(1, cs_b, sclk_b, rx_b, err_b, des_b, data_b, word_b);
    if (cs_b) begin
      rc_b = 0; lw_b = word_b; sdata_b = word_b[15];
    end else if (!prev_sclk_b && sclk_b) begin
      rc_b++;
      sdata_b = (rc_b < 16) ? lw_b[4'(15 - rc_b)] : 1'b0;
    end
    prev_cs_b = cs_b; prev_sclk_b = sclk_b;
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  // which: 0 = next Rx_Listo on A, 1 = next Cs fall on A, 2 = eighth Sclk rise on A
  task automatic wait_evt(input int which, input int budget, input string name);
    int start, n;
    bit ok;
    start = (which == 0) ? a_rx : a_csf;
    n = 0;
    ok = 0;
    while (!ok && n < budget) begin
      step(1);
      n++;
      case (which)
        0: ok = (a_rx != start);
        1: ok = (a_csf != start);
        default: ok = (a_rises >= 8);
      endcase
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  int s_csf, s_rx, s_des;

  initial begin
    Rst = 1'b1; Habilita = 1'b1;
    step(3);
    Rst = 1'b0;
    chk("rst_cs", 32'(cs_a), 32'd1);
    chk("rst_sclk", 32'(sclk_a), 32'd1);
    chk("rst_data", 32'(data_a), 32'h0);
    chk("rst_rx", 32'(rx_a), 32'd0);
    chk("rst_des", 32'(des_a), 32'd0);

    wait_evt(0, 300, "rx1_timeout");
    chk("lat1", 32'(t_rx_a - t_csf_a + 1), 32'd65);
    chk("data1", 32'(data_a), 32'hA5C);
    chk("err1", 32'(err_a), 32'd0);
    chk("falls1", 32'(a_falls), 32'd16);
    word_a = 16'h8FFF;
    wait_evt(0, 200, "rx2_timeout");
    chk("data2", 32'(data_a), 32'hFFF);
    chk("err2", 32'(err_a), 32'd1);
    word_a = 16'h0001;
    wait_evt(0, 200, "rx3_timeout");
    chk("data3", 32'(data_a), 32'h001);
    chk("err3", 32'(err_a), 32'd0);
    chk("b_csf_window", 32'(b_csf), 32'd2);
    chk("b_des_window", 32'(b_des), 32'd1);
    b_win = 0;

    Habilita = 1'b0;
    s_csf = a_csf; s_rx = a_rx; s_des = a_des;
    step(300);
    chk("off_csf", 32'(a_csf - s_csf), 32'd0);
    chk("off_rx", 32'(a_rx - s_rx), 32'd0);
    chk("off_des", 32'(a_des - s_des), 32'd0);

    word_a = 16'h0C3A;
    Habilita = 1'b1;
    wait_evt(1, 200, "csf4_timeout");
    step(10);
    Habilita = 1'b0;
    wait_evt(0, 200, "rx4_timeout");
    chk("data4", 32'(data_a), 32'hC3A);
    chk("falls4", 32'(a_falls), 32'd16);
    s_csf = a_csf;
    step(250);
    chk("idle_csf", 32'(a_csf - s_csf), 32'd0);

    word_a = 16'h7123;
    Habilita = 1'b1;
    wait_evt(1, 200, "csf5_timeout");
    wait_evt(2, 200, "rise8_timeout");
    Rst = 1'b1;
    step(1);
    Rst = 1'b0;
    chk("abort_cs", 32'(cs_a), 32'd1);
    chk("abort_data", 32'(data_a), 32'h0);
    s_rx = a_rx;
    step(50);
    chk("abort_rx", 32'(a_rx - s_rx), 32'd0);
    chk("abort_data_hold", 32'(data_a), 32'h0);
    wait_evt(0, 200, "rx6_timeout");
    chk("lat6", 32'(t_rx_a - t_csf_a + 1), 32'd65);
    chk("data6", 32'(data_a), 32'h123);
    chk("err6", 32'(err_a), 32'd1);
    chk("falls6", 32'(a_falls), 32'd16);

    step(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
